enemy_spawn_scheduler: RTL and testbench
========================================

# enemy_spawn_scheduler

Sequences enemy-vehicle spawns on the road for the car/truck drawing path. Each cycle of the block waits a frame-counted gap, picks car or truck and a lane from an LFSR, then issues a one-cycle spawn pulse. It holds `create_truck` stable for the car/truck output mux and waits for the object engine to acknowledge and retire the enemy before scheduling the next one. The spawn gap shrinks as the game progresses.

## Interface
Parameters:
- `GAP_INIT`, 60: initial spawn gap in frames (range 2..255).
- `GAP_MIN`, 20: floor of the spawn gap in frames (2 ≤ `GAP_MIN` ≤ `GAP_INIT`).
- `GAP_STEP`, 4: frames removed from the gap every 8 spawns.
- `TRUCK_THRESH`, 4: truck chosen when `lfsr[3:0] < TRUCK_THRESH` (4 means 25%).
- `MAX_TRUCK_STREAK`, 2: maximum number of consecutive trucks.
- `LANE_X0`, 160: x of lane 0 in pixels.
- `LANE_W`, 80: lane pitch in pixels.
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR; must be non-zero.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `startOfFrame`  in  1: one-cycle pulse per video frame.
- `enable`  in  1: game running.
- `object_ready`  in  1: high means the enemy slot is free; low means an enemy is active.
- `spawn`  out  1: one-cycle spawn command.
- `create_truck`  out  1: type of the latest spawn (1 = truck), held between spawns.
- `spawn_lane`  out  2: lane index, valid while `spawn` is high and held afterwards.
- `spawn_x`  out  11: `LANE_X0 + spawn_lane*LANE_W`, registered together with `spawn_lane`.
- `gap_frames`  out  8: current gap length.
- `busy`  out  1: high in `WAIT_ACK` and `WAIT_DONE`.

## Operation
Free-running logic:
- The LFSR is a 16-bit Galois LFSR with taps 16, 14, 13, 11 (mask 16'hB400). It shifts every clock, including while `enable` is low.

States are IDLE, GAP, SPAWN, WAIT_ACK and WAIT_DONE:
- **IDLE**: go to GAP when `enable` is high and `object_ready` is high. Clear `frame_cnt` on entry.
- **GAP**: `frame_cnt` increments on each `startOfFrame`. When a pulse arrives with `frame_cnt == gap_frames-1`, go to SPAWN.
- **SPAWN** (one cycle): `spawn` = 1. Register the choice from the current LFSR value:
  - Truck when `lfsr[3:0] < TRUCK_THRESH` and `truck_streak < MAX_TRUCK_STREAK`; otherwise car.
  - `spawn_lane = lfsr[5:4]`.
  - A truck increments `truck_streak`, saturating; a car clears it.
  - `spawn_cnt` (3 bits) increments and wraps. On the wrap from 7 to 0, `gap_frames = max(gap_frames - GAP_STEP, GAP_MIN)`, computed in 9 bits so it cannot underflow.
  - Go to WAIT_ACK.
- **WAIT_ACK**: wait for `object_ready` == 0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `object_ready` == 1, then go to GAP with `frame_cnt` cleared.

Boundary rules:
- `enable` low in any state other than SPAWN: go to IDLE at the next edge.
  - `frame_cnt` is cleared.
  - `create_truck`, `spawn_lane`, `spawn_x`, `gap_frames`, `truck_streak` and `spawn_cnt` are held.
- `enable` low in SPAWN: the spawn still completes for that cycle, then the block goes to IDLE.
- Enemy retired early: if `object_ready` is high at entry to WAIT_ACK, the block stays in WAIT_ACK. There is no timeout; this is a system-level error.
- `startOfFrame` is ignored outside GAP.
- `create_truck` changes only in the SPAWN cycle.

## Timing
Reset values (checked at the first edge with `reset` = 1):
- State IDLE; `spawn` 0, `create_truck` 0, `spawn_lane` 0, `spawn_x` = `LANE_X0`, `gap_frames` = `GAP_INIT`, `busy` 0.
- LFSR = `LFSR_SEED`; `frame_cnt`, `truck_streak` and `spawn_cnt` = 0.

Reset behaviour:
- Reset overrides every transition and outputs, including a reset asserted in the SPAWN cycle. That spawn pulse is dropped and the counters do not advance.

Latency and output timing:
- Final gap `startOfFrame` to `spawn` high: 1 clock.
- `spawn`, `create_truck`, `spawn_lane` and `spawn_x` are all registered. They change on the same edge, so they are coherent in the `spawn` cycle.
- `busy` rises on the edge after `spawn` rises.
- Minimum spacing between spawns: `gap_frames` frames after `object_ready` returns high.

## Test plan
- **Reset:** assert `reset` for 2 clocks with `enable` = 1 and `object_ready` = 1 → all outputs at reset values; the first `spawn` comes exactly 1 clock after the 60th `startOfFrame` following GAP entry.
- **Handshake:** after `spawn`, hold `object_ready` = 1 for 100 frames → no second `spawn`, `busy` = 1. Then drive 0, then 1 → the next `spawn` follows 60 frames later.
- **Truck streak:** force the LFSR via `LFSR_SEED` = 16'h0001 and check over 200 spawns → never 3 consecutive `create_truck` = 1, and the truck ratio is within 15–35%.
- **Gap ramp:** complete 80 spawns → `gap_frames` steps 60, 56, 52, …, 24, 20 and then stays at 20.
- **Enable drop:** deassert `enable` mid-GAP at frame 30 → IDLE. Reassert → the full 60-frame gap restarts, and `create_truck` is unchanged throughout.
- **Lane mapping:** for each lane 0..3 at spawn → `spawn_x` = 160, 240, 320, 400 respectively.

Source files
------------

// File: rtl/enemy_spawn_scheduler_if.sv
// Handshake and status bundle between the spawn scheduler and the game/object logic.
interface enemy_spawn_scheduler_if;
  logic        startOfFrame;
  logic        enable;
  logic        object_ready;
  logic        spawn;
  logic        create_truck;
  logic [1:0]  spawn_lane;
  logic [10:0] spawn_x;
  logic [7:0]  gap_frames;
  logic        busy;

  // Game/object side: drives frame timing, enable and slot status.
  modport master (
    output startOfFrame, enable, object_ready,
    input  spawn, create_truck, spawn_lane, spawn_x, gap_frames, busy
  );

  // Scheduler side.
  modport slave (
    input  startOfFrame, enable, object_ready,
    output spawn, create_truck, spawn_lane, spawn_x, gap_frames, busy
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: frame-counted gap, LFSR car/truck and lane pick,
// one-cycle spawn pulse, then waits for the object slot to be used and freed.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | game stopped or waiting for a free slot before the first gap
// GAP       | counting startOfFrame pulses until the gap has elapsed
// SPAWN     | spawn pulse high; type/lane/x already registered
// WAIT_ACK  | waiting for the object engine to take the slot (ready low)
// WAIT_DONE | waiting for the enemy to be retired (ready high again)
module enemy_spawn_scheduler #(
  parameter int          GAP_INIT         = 60,
  parameter int          GAP_MIN          = 20,
  parameter int          GAP_STEP         = 4,
  parameter int          TRUCK_THRESH     = 4,
  parameter int          MAX_TRUCK_STREAK = 2,
  parameter int          LANE_X0          = 160,
  parameter int          LANE_W           = 80,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic                    clk,
  input logic                    reset,
  enemy_spawn_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GAP, SPAWN, WAIT_ACK, WAIT_DONE
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  truck_streak_q;
  logic [2:0]  spawn_cnt_q;
  logic [7:0]  gap_q, gap_dec_d;
  logic [8:0]  gap_sub;
  logic        spawn_q, truck_q, busy_q;
  logic [1:0]  lane_q;
  logic [10:0] x_q, x_d;
  logic        pick_truck_d;

  // LFSR step, spawn choice and next-gap arithmetic from the current state.
  always_comb begin
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pick_truck_d = ({28'd0, lfsr_q[3:0]} < TRUCK_THRESH) &&
                   ({24'd0, truck_streak_q} < MAX_TRUCK_STREAK);
    x_d          = 11'(LANE_X0) + 11'(LANE_W) * {9'd0, lfsr_q[5:4]};
    // 9-bit subtract: a borrow shows up in bit 8 and clamps to the floor.
    gap_sub      = {1'b0, gap_q} - 9'(GAP_STEP);
    gap_dec_d    = (gap_sub[8] || (gap_sub < 9'(GAP_MIN))) ? 8'(GAP_MIN) : gap_sub[7:0];
  end

  // Sequencer with registered outputs; the spawn choice is latched on the
  // edge that enters SPAWN so all spawn outputs change together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_SEED;
      frame_cnt_q    <= 8'd0;
      truck_streak_q <= 8'd0;
      spawn_cnt_q    <= 3'd0;
      gap_q          <= 8'(GAP_INIT);
      spawn_q        <= 1'b0;
      truck_q        <= 1'b0;
      lane_q         <= 2'd0;
      x_q            <= 11'(LANE_X0);
      busy_q         <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      spawn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          frame_cnt_q <= 8'd0;
          busy_q      <= 1'b0;
          if (bus.enable && bus.object_ready) state_q <= GAP;
        end
        GAP: begin
          if (!bus.enable) begin
            state_q     <= IDLE;
            frame_cnt_q <= 8'd0;
          end else if (bus.startOfFrame) begin
            if (frame_cnt_q == gap_q - 8'd1) begin
              state_q     <= SPAWN;
              frame_cnt_q <= 8'd0;
              spawn_q     <= 1'b1;
              truck_q     <= pick_truck_d;
              lane_q      <= lfsr_q[5:4];
              x_q         <= x_d;
              spawn_cnt_q <= spawn_cnt_q + 3'd1;
              if (spawn_cnt_q == 3'd7) gap_q <= gap_dec_d;
              if (!pick_truck_d)                 truck_streak_q <= 8'd0;
              else if (truck_streak_q != 8'hFF)  truck_streak_q <= truck_streak_q + 8'd1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        SPAWN: begin
          frame_cnt_q <= 8'd0;
          state_q     <= bus.enable ? WAIT_ACK : IDLE;
          busy_q      <= bus.enable;
        end
        WAIT_ACK: begin
          if (!bus.enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!bus.object_ready) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.object_ready) begin
            state_q     <= GAP;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spawn        = spawn_q;
  assign bus.create_truck = truck_q;
  assign bus.spawn_lane   = lane_q;
  assign bus.spawn_x      = x_q;
  assign bus.gap_frames   = gap_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: reference LFSR model feeds a scoreboard of
// expected spawns; a gap-ramp table plus hand sequences for handshake/enable.
module tb_enemy_spawn_scheduler;
  localparam logic [15:0] SEED = 16'h0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enemy_spawn_scheduler_if bus();

  enemy_spawn_scheduler #(.LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        truck;
    logic [1:0]  lane;
    logic [10:0] x;
  } exp_t;

  typedef struct {
    int         spawns;
    logic [7:0] gap;
  } gap_vec_t;

  exp_t        sb_q[$];
  gap_vec_t    gap_tab[14];
  logic [10:0] lane_x_tab[4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference LFSR, stepped on the same edges as the DUT.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int   m_streak     = 0;
  logic m_last_truck = 1'b0;

  function automatic int gap_for(input int spawns_done);
    int g;
    g = 60 - 4 * (spawns_done / 8);
    return (g < 20) ? 20 : g;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.truck = (m_lfsr[3:0] < 4'd4) && (m_streak < 2);
    m_streak = e.truck ? m_streak + 1 : 0;
    e.lane  = m_lfsr[5:4];
    e.x     = lane_x_tab[e.lane];
    m_last_truck = e.truck;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each spawn and gathers streak statistics.
  int       n_spawn_obs  = 0;
  int       n_trucks     = 0;
  int       run          = 0;
  int       max_run      = 0;
  int       bad_changes  = 0;
  logic [3:0] lanes_seen = 4'h0;
  logic     prev_truck   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.spawn) begin
      check("spawn_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("create_truck", 32'(bus.create_truck), 32'(e.truck));
        check("spawn_lane",   32'(bus.spawn_lane),   32'(e.lane));
        check("spawn_x",      32'(bus.spawn_x),      32'(e.x));
      end
      n_spawn_obs++;
      lanes_seen[bus.spawn_lane] = 1'b1;
      if (bus.create_truck) begin
        n_trucks++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    if (!reset && !bus.spawn && (bus.create_truck !== prev_truck)) bad_changes++;
    prev_truck = bus.create_truck;
  end

  // Issue n frame pulses two clocks apart; the last may be the final gap frame.
  task automatic send_frames(input int n, input bit final_spawn, input bit drop_en);
    for (int i = 0; i < n; i++) begin
      bus.startOfFrame = 1'b1;
      if (final_spawn && i == n - 1) push_expected();
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      if (final_spawn && i == n - 1) begin
        check("spawn_latency", 32'(bus.spawn), 32'd1);
        if (drop_en) bus.enable = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic retire();
    bus.object_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.object_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int done;
    lane_x_tab[0] = 11'd160; lane_x_tab[1] = 11'd240;
    lane_x_tab[2] = 11'd320; lane_x_tab[3] = 11'd400;
    gap_tab[0]  = '{4,   8'd60}; gap_tab[1]  = '{8,   8'd56};
    gap_tab[2]  = '{16,  8'd52}; gap_tab[3]  = '{24,  8'd48};
    gap_tab[4]  = '{32,  8'd44}; gap_tab[5]  = '{40,  8'd40};
    gap_tab[6]  = '{48,  8'd36}; gap_tab[7]  = '{56,  8'd32};
    gap_tab[8]  = '{64,  8'd28}; gap_tab[9]  = '{72,  8'd24};
    gap_tab[10] = '{80,  8'd20}; gap_tab[11] = '{88,  8'd20};
    gap_tab[12] = '{120, 8'd20}; gap_tab[13] = '{200, 8'd20};

    bus.startOfFrame = 1'b0;
    bus.enable       = 1'b1;
    bus.object_ready = 1'b1;
    reset            = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_spawn",        32'(bus.spawn),        32'd0);
    check("rst_create_truck", 32'(bus.create_truck), 32'd0);
    check("rst_spawn_lane",   32'(bus.spawn_lane),   32'd0);
    check("rst_spawn_x",      32'(bus.spawn_x),      32'd160);
    check("rst_gap_frames",   32'(bus.gap_frames),   32'd60);
    check("rst_busy",         32'(bus.busy),         32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // First spawn exactly on the 60th frame; busy follows one edge later.
    send_frames(60, 1'b1, 1'b0);
    check("busy_after_spawn", 32'(bus.busy), 32'd1);

    // Slot never taken: no further spawn however many frames pass.
    send_frames(100, 1'b0, 1'b0);
    check("busy_while_unacked", 32'(bus.busy), 32'd1);
    check("spawns_while_unacked", 32'(n_spawn_obs), 32'd1);
    retire();
    check("busy_after_retire", 32'(bus.busy), 32'd0);
    send_frames(60, 1'b1, 1'b0);
    retire();

    // Enable drop mid-gap restarts the full gap; type output is held.
    send_frames(30, 1'b0, 1'b0);
    bus.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_create_truck_held", 32'(bus.create_truck), 32'(m_last_truck));
    send_frames(80, 1'b0, 1'b0);
    bus.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send_frames(60, 1'b1, 1'b0);
    retire();

    // Enable low during the spawn cycle: pulse completes, then back to IDLE.
    send_frames(60, 1'b1, 1'b1);
    check("spawn_en_drop_busy", 32'(bus.busy), 32'd0);
    check("spawn_en_drop_count", 32'(n_spawn_obs), 32'd4);
    bus.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Gap ramp table.
    done = 4;
    for (int t = 0; t < 14; t++) begin
      while (done < gap_tab[t].spawns) begin
        send_frames(gap_for(done), 1'b1, 1'b0);
        retire();
        done++;
      end
      check("gap_ramp", 32'(bus.gap_frames), 32'(gap_tab[t].gap));
    end

    check("total_spawns",       32'(n_spawn_obs), 32'd200);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("max_truck_streak_le2", 32'(max_run <= 2), 32'd1);
    check("truck_ratio_15_35pct",
          32'((n_trucks * 100 >= 15 * n_spawn_obs) && (n_trucks * 100 <= 35 * n_spawn_obs)), 32'd1);
    check("all_lanes_seen", 32'(lanes_seen), 32'hF);
    check("create_truck_only_on_spawn", 32'(bad_changes), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
